// File: rtl/id_pkg.sv
// Shared constants for the decode-stage resolution logic: field widths and
// the branch/jump operation encodings carried on br_op.
package id_pkg;

  localparam int unsigned BROP_W = 4;
  localparam int unsigned RA_W   = 5;

  localparam logic [BROP_W-1:0] BR_NONE = 4'd0;
  localparam logic [BROP_W-1:0] BR_BEQ  = 4'd1;
  localparam logic [BROP_W-1:0] BR_BNE  = 4'd2;
  localparam logic [BROP_W-1:0] BR_BLEZ = 4'd3;
  localparam logic [BROP_W-1:0] BR_BGTZ = 4'd4;
  localparam logic [BROP_W-1:0] BR_BLTZ = 4'd5;
  localparam logic [BROP_W-1:0] BR_BGEZ = 4'd6;
  localparam logic [BROP_W-1:0] BR_J    = 4'd7;
  localparam logic [BROP_W-1:0] BR_JR   = 4'd8;

  // Conditional branches share the PC-relative target computation.
  function automatic logic is_cond_branch(input logic [BROP_W-1:0] op);
    return (op >= BR_BEQ) && (op <= BR_BGEZ);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-operand bypass selector: picks the youngest in-flight producer of a
// source register, falling back to the register-file read data.
module fwd_mux
  import id_pkg::*;
(
  input  logic [RA_W-1:0] ra,
  input  logic [31:0]     rf_rd,
  input  logic            ex_we,
  input  logic            ex_load,
  input  logic [RA_W-1:0] ex_wa,
  input  logic [31:0]     ex_alu,
  input  logic            mem_we,
  input  logic            mem_load,
  input  logic [RA_W-1:0] mem_wa,
  input  logic [31:0]     mem_alu,
  input  logic [31:0]     mem_rdata,
  input  logic            wb_we,
  input  logic [RA_W-1:0] wb_wa,
  input  logic [31:0]     wb_data,
  output logic [31:0]     fwd
);

  logic ra_nz;
  logic hit_ex;
  logic hit_mem;
  logic hit_wb;

  assign ra_nz   = (ra != '0);
  // A load in EX has no data yet; the hazard logic stalls instead.
  assign hit_ex  = ra_nz && ex_we && !ex_load && (ex_wa == ra);
  assign hit_mem = ra_nz && mem_we && (mem_wa == ra);
  assign hit_wb  = ra_nz && wb_we && (wb_wa == ra);

  always_comb begin
    fwd = rf_rd;
    if (hit_ex)
      fwd = ex_alu;
    else if (hit_mem)
      fwd = mem_load ? mem_rdata : mem_alu;
    else if (hit_wb)
      fwd = wb_data;
  end

endmodule

// File: rtl/id_resolve_unit.sv
// ID-stage resolution: immediate extension, operand bypassing, load-use
// stall detection, branch/jump evaluation and a saturating stall counter.
module id_resolve_unit
  import id_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BROP_W-1:0] br_op,
  input  logic [31:0]       pc_plus4,
  input  logic [15:0]       branch_offset,
  input  logic [25:0]       jump_target,
  input  logic [15:0]       imm,
  input  logic              imm_sign,
  input  logic [RA_W-1:0]   ra1,
  input  logic [RA_W-1:0]   ra2,
  input  logic              use1,
  input  logic              use2,
  input  logic [31:0]       rf_rd1,
  input  logic [31:0]       rf_rd2,
  input  logic              ex_we,
  input  logic              ex_load,
  input  logic [RA_W-1:0]   ex_wa,
  input  logic [31:0]       ex_alu,
  input  logic              mem_we,
  input  logic              mem_load,
  input  logic [RA_W-1:0]   mem_wa,
  input  logic [31:0]       mem_alu,
  input  logic [31:0]       mem_rdata,
  input  logic              wb_we,
  input  logic [RA_W-1:0]   wb_wa,
  input  logic [31:0]       wb_data,
  output logic [31:0]       imm_ext,
  output logic [31:0]       rd1,
  output logic [31:0]       rd2,
  output logic              pause,
  output logic              br_taken,
  output logic [31:0]       br_target,
  output logic [31:0]       stall_cnt
);

  assign imm_ext = imm_sign ? {{16{imm[15]}}, imm} : {16'h0000, imm};

  fwd_mux u_fwd1 (
    .ra        (ra1),
    .rf_rd     (rf_rd1),
    .ex_we     (ex_we),
    .ex_load   (ex_load),
    .ex_wa     (ex_wa),
    .ex_alu    (ex_alu),
    .mem_we    (mem_we),
    .mem_load  (mem_load),
    .mem_wa    (mem_wa),
    .mem_alu   (mem_alu),
    .mem_rdata (mem_rdata),
    .wb_we     (wb_we),
    .wb_wa     (wb_wa),
    .wb_data   (wb_data),
    .fwd       (rd1)
  );

  fwd_mux u_fwd2 (
    .ra        (ra2),
    .rf_rd     (rf_rd2),
    .ex_we     (ex_we),
    .ex_load   (ex_load),
    .ex_wa     (ex_wa),
    .ex_alu    (ex_alu),
    .mem_we    (mem_we),
    .mem_load  (mem_load),
    .mem_wa    (mem_wa),
    .mem_alu   (mem_alu),
    .mem_rdata (mem_rdata),
    .wb_we     (wb_we),
    .wb_wa     (wb_wa),
    .wb_data   (wb_data),
    .fwd       (rd2)
  );

  logic load_in_ex;
  assign load_in_ex = ex_we && ex_load && (ex_wa != '0);
  assign pause = load_in_ex &&
                 ((use1 && (ex_wa == ra1)) || (use2 && (ex_wa == ra2)));

  logic        cond;
  logic [31:0] rel_target;
  logic [31:0] abs_target;
  logic        rd1_zero;
  logic        rd1_neg;

  assign rel_target = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign abs_target = {pc_plus4[31:28], jump_target, 2'b00};
  assign rd1_zero   = (rd1 == '0);
  assign rd1_neg    = rd1[31];

  always_comb begin
    cond = 1'b0;
    unique case (br_op)
      BR_BEQ:  cond = (rd1 == rd2);
      BR_BNE:  cond = (rd1 != rd2);
      BR_BLEZ: cond = rd1_neg || rd1_zero;
      BR_BGTZ: cond = !rd1_neg && !rd1_zero;
      BR_BLTZ: cond = rd1_neg;
      BR_BGEZ: cond = !rd1_neg;
      BR_J:    cond = 1'b1;
      BR_JR:   cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    br_target = pc_plus4;
    if (is_cond_branch(br_op))
      br_target = rel_target;
    else if (br_op == BR_J)
      br_target = abs_target;
    else if (br_op == BR_JR)
      br_target = rd1;
  end

  assign br_taken = cond && !pause;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if (pause && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 32'd1;
  end

endmodule

// File: tb/tb_id_resolve_unit.sv
// Scoreboarded bench for id_resolve_unit: directed and random stimulus,
// expectations from a behavioural model, checked by a separate monitor.
module tb_id_resolve_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  br_op;
  logic [31:0] pc_plus4;
  logic [15:0] branch_offset;
  logic [25:0] jump_target;
  logic [15:0] imm;
  logic        imm_sign;
  logic [4:0]  ra1, ra2;
  logic        use1, use2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        ex_we, ex_load;
  logic [4:0]  ex_wa;
  logic [31:0] ex_alu;
  logic        mem_we, mem_load;
  logic [4:0]  mem_wa;
  logic [31:0] mem_alu, mem_rdata;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_data;
  logic [31:0] imm_ext, rd1, rd2, br_target, stall_cnt;
  logic        pause, br_taken;

  id_resolve_unit dut (
    .clk(clk), .rst(rst), .br_op(br_op), .pc_plus4(pc_plus4),
    .branch_offset(branch_offset), .jump_target(jump_target),
    .imm(imm), .imm_sign(imm_sign), .ra1(ra1), .ra2(ra2),
    .use1(use1), .use2(use2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .ex_we(ex_we), .ex_load(ex_load), .ex_wa(ex_wa), .ex_alu(ex_alu),
    .mem_we(mem_we), .mem_load(mem_load), .mem_wa(mem_wa),
    .mem_alu(mem_alu), .mem_rdata(mem_rdata), .wb_we(wb_we),
    .wb_wa(wb_wa), .wb_data(wb_data), .imm_ext(imm_ext), .rd1(rd1),
    .rd2(rd2), .pause(pause), .br_taken(br_taken), .br_target(br_target),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] pc;
    logic [15:0] off;
    logic [25:0] jt;
    logic [15:0] imm;
    logic        sgn;
    logic [4:0]  ra1, ra2;
    logic        use1, use2;
    logic [31:0] rf1, rf2;
    logic        ex_we, ex_load;
    logic [4:0]  ex_wa;
    logic [31:0] ex_alu;
    logic        mem_we, mem_load;
    logic [4:0]  mem_wa;
    logic [31:0] mem_alu, mem_rdata;
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_data;
  } stim_t;

  typedef struct {
    logic [31:0] imm_ext, rd1, rd2, br_target, stall_cnt;
    logic        pause, br_taken;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  longint      ref_cnt = 0;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.pc = 32'h0000_2000;
    return s;
  endfunction

  // Producers listed youngest first; the first one that writes ra supplies it.
  function automatic logic [31:0] model_fwd(logic [4:0] ra, logic [31:0] rf, stim_t s);
    logic        valid [3];
    logic [4:0]  dest  [3];
    logic [31:0] data  [3];
    valid[0] = s.ex_we && !s.ex_load; dest[0] = s.ex_wa;  data[0] = s.ex_alu;
    valid[1] = s.mem_we;              dest[1] = s.mem_wa; data[1] = s.mem_load ? s.mem_rdata : s.mem_alu;
    valid[2] = s.wb_we;               dest[2] = s.wb_wa;  data[2] = s.wb_data;
    if (ra == 0) return rf;
    for (int i = 0; i < 3; i++)
      if (valid[i] && dest[i] == ra) return data[i];
    return rf;
  endfunction

  function automatic exp_t model(stim_t s);
    exp_t e;
    int   a, b;
    bit   cond, stall;
    e.tag = "";
    e.imm_ext = s.sgn ? 32'($signed(s.imm)) : 32'(s.imm);
    e.rd1 = model_fwd(s.ra1, s.rf1, s);
    e.rd2 = model_fwd(s.ra2, s.rf2, s);
    stall = s.ex_we && s.ex_load && s.ex_wa != 0 &&
            ((s.use1 && s.ex_wa == s.ra1) || (s.use2 && s.ex_wa == s.ra2));
    a = int'(e.rd1);
    b = int'(e.rd2);
    case (s.op)
      4'd1: cond = (a == b);
      4'd2: cond = (a != b);
      4'd3: cond = (a <= 0);
      4'd4: cond = (a > 0);
      4'd5: cond = (a < 0);
      4'd6: cond = (a >= 0);
      4'd7, 4'd8: cond = 1;
      default: cond = 0;
    endcase
    if (s.op >= 1 && s.op <= 6)
      e.br_target = s.pc + 32'(int'($signed(s.off)) * 4);
    else if (s.op == 7)
      e.br_target = (s.pc & 32'hF000_0000) | (32'(s.jt) << 2);
    else if (s.op == 8)
      e.br_target = e.rd1;
    else
      e.br_target = s.pc;
    e.pause = stall;
    e.br_taken = cond && !stall;
    e.stall_cnt = 32'(ref_cnt);
    return e;
  endfunction

  // Drives one cycle of stimulus just after a rising edge and queues its
  // expectation; the counter model advances at the following rising edge.
  task automatic apply(stim_t s, bit rst_lvl, string tag);
    exp_t e;
    @(posedge clk);
    #1;
    br_op = s.op; pc_plus4 = s.pc; branch_offset = s.off; jump_target = s.jt;
    imm = s.imm; imm_sign = s.sgn; ra1 = s.ra1; ra2 = s.ra2;
    use1 = s.use1; use2 = s.use2; rf_rd1 = s.rf1; rf_rd2 = s.rf2;
    ex_we = s.ex_we; ex_load = s.ex_load; ex_wa = s.ex_wa; ex_alu = s.ex_alu;
    mem_we = s.mem_we; mem_load = s.mem_load; mem_wa = s.mem_wa;
    mem_alu = s.mem_alu; mem_rdata = s.mem_rdata;
    wb_we = s.wb_we; wb_wa = s.wb_wa; wb_data = s.wb_data;
    rst = rst_lvl;
    if (!rst_lvl) ref_cnt = 0;
    e = model(s);
    e.tag = tag;
    sb.push_back(e);
    if (rst_lvl && e.pause && ref_cnt < 64'hFFFF_FFFF) ref_cnt++;
  endtask

  task automatic chk(string name, string tag, logic [31:0] act, logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s.%s actual=%h required=%h", tag, name, act, req);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("imm_ext",   e.tag, imm_ext,   e.imm_ext);
        chk("rd1",       e.tag, rd1,       e.rd1);
        chk("rd2",       e.tag, rd2,       e.rd2);
        chk("pause",     e.tag, 32'(pause),    32'(e.pause));
        chk("br_taken",  e.tag, 32'(br_taken), 32'(e.br_taken));
        chk("br_target", e.tag, br_target, e.br_target);
        chk("stall_cnt", e.tag, stall_cnt, e.stall_cnt);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "time limit");
  end

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 3))
      0: return 32'h0;
      1: return 32'($urandom_range(0, 3));
      2: return 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
      default: return $urandom;
    endcase
  endfunction

  initial begin : stimulus
    stim_t s;
    apply(idle(), 1'b0, "reset");

    s = idle(); s.imm = 16'h8001; s.sgn = 1;
    apply(s, 1'b1, "imm_sext");
    s.sgn = 0;
    apply(s, 1'b1, "imm_zext");

    s = idle(); s.ra1 = 5; s.rf1 = 32'd99;
    s.ex_we = 1;  s.ex_wa = 5;  s.ex_alu = 32'd11;
    s.mem_we = 1; s.mem_wa = 5; s.mem_alu = 32'd22;
    s.wb_we = 1;  s.wb_wa = 5;  s.wb_data = 32'd33;
    apply(s, 1'b1, "fwd_ex");
    s.ex_we = 0;
    apply(s, 1'b1, "fwd_mem");
    s.mem_we = 0;
    apply(s, 1'b1, "fwd_wb");
    s.ex_we = 1; s.mem_we = 1; s.ra1 = 0;
    s.ex_wa = 0; s.mem_wa = 0; s.wb_wa = 0; s.rf1 = 32'h0;
    apply(s, 1'b1, "fwd_r0");

    s = idle(); s.op = 4'd1; s.ra1 = 4; s.ra2 = 3; s.use1 = 1; s.use2 = 1;
    s.rf1 = 32'd7; s.rf2 = 32'd7;
    s.ex_we = 1; s.ex_load = 1; s.ex_wa = 3; s.ex_alu = 32'h1234;
    s.mem_we = 1; s.mem_load = 1; s.mem_wa = 3; s.mem_rdata = 32'd7;
    s.off = 16'h0010;
    for (int i = 0; i < 3; i++) apply(s, 1'b1, "load_use");
    s.use2 = 0;
    apply(s, 1'b1, "no_use");

    s = idle(); s.op = 4'd2; s.pc = 32'h0000_1000; s.off = 16'hFFFF;
    s.ra1 = 1; s.ra2 = 2; s.rf1 = 32'd1; s.rf2 = 32'd2;
    apply(s, 1'b1, "bne_back");
    s.op = 4'd6; s.rf1 = 32'h8000_0000;
    apply(s, 1'b1, "bgez_neg");

    s = idle(); s.op = 4'd7; s.pc = 32'hA000_0004; s.jt = 26'h3FF_FFFF;
    apply(s, 1'b1, "jump");
    s = idle(); s.op = 4'd8; s.ra1 = 9; s.use1 = 1; s.rf1 = 32'hDEAD_0000;
    s.ex_we = 1; s.ex_wa = 9; s.ex_alu = 32'h0040_0020;
    apply(s, 1'b1, "jr_fwd");

    s = idle(); s.ra1 = 6; s.use1 = 1; s.ex_we = 1; s.ex_load = 1; s.ex_wa = 6;
    for (int i = 0; i < 3; i++) apply(s, 1'b1, "stall_pre");
    apply(s, 1'b0, "stall_rst");
    for (int i = 0; i < 3; i++) apply(s, 1'b1, "stall_post");

    for (int n = 0; n < 400; n++) begin
      s.op = 4'($urandom_range(0, 15));
      s.pc = $urandom; s.off = 16'($urandom); s.jt = 26'($urandom);
      s.imm = 16'($urandom); s.sgn = 1'($urandom);
      s.ra1 = 5'($urandom_range(0, 7)); s.ra2 = 5'($urandom_range(0, 7));
      s.use1 = 1'($urandom); s.use2 = 1'($urandom);
      s.rf1 = (s.ra1 == 0) ? 32'h0 : pick_val();
      s.rf2 = (s.ra2 == 0) ? 32'h0 : pick_val();
      s.ex_we = 1'($urandom); s.ex_load = ($urandom_range(0, 3) == 0);
      s.ex_wa = 5'($urandom_range(0, 7)); s.ex_alu = pick_val();
      s.mem_we = 1'($urandom); s.mem_load = 1'($urandom);
      s.mem_wa = 5'($urandom_range(0, 7));
      s.mem_alu = pick_val(); s.mem_rdata = pick_val();
      s.wb_we = 1'($urandom); s.wb_wa = 5'($urandom_range(0, 7));
      s.wb_data = pick_val();
      apply(s, ($urandom_range(0, 49) != 0), "random");
    end

    @(posedge clk);
    @(posedge clk);
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain actual=%0d required=0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
